// File: rtl/freq_ratio_phase_collector.sv
// Collects a single-phase DFI stream and re-packs it into up to four phases
// (p0..p3) according to the 1:1, 1:2 or 1:4 frequency ratio latched at group start.
module freq_ratio_phase_collector #(
    parameter int NUM_RANK    = 2,
    parameter int DEVICE_TYPE = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic [2:0]                 dfi_freq_ratio,
    input  logic [NUM_RANK-1:0]        dfi_cs_n,
    input  logic [NUM_RANK-1:0]        dfi_reset_n,
    input  logic [13:0]                dfi_address,
    input  logic                       dfi_wrdata_en,
    input  logic [2*DEVICE_TYPE-1:0]   dfi_wrdata,
    input  logic [DEVICE_TYPE/4-1:0]   dfi_wrdata_mask,
    output logic [NUM_RANK-1:0]        dfi_cs_n_p0,
    output logic [NUM_RANK-1:0]        dfi_cs_n_p1,
    output logic [NUM_RANK-1:0]        dfi_cs_n_p2,
    output logic [NUM_RANK-1:0]        dfi_cs_n_p3,
    output logic [NUM_RANK-1:0]        dfi_reset_n_p0,
    output logic [NUM_RANK-1:0]        dfi_reset_n_p1,
    output logic [NUM_RANK-1:0]        dfi_reset_n_p2,
    output logic [NUM_RANK-1:0]        dfi_reset_n_p3,
    output logic [13:0]                dfi_address_p0,
    output logic [13:0]                dfi_address_p1,
    output logic [13:0]                dfi_address_p2,
    output logic [13:0]                dfi_address_p3,
    output logic                       dfi_wrdata_en_p0,
    output logic                       dfi_wrdata_en_p1,
    output logic                       dfi_wrdata_en_p2,
    output logic                       dfi_wrdata_en_p3,
    output logic [2*DEVICE_TYPE-1:0]   dfi_wrdata_p0,
    output logic [2*DEVICE_TYPE-1:0]   dfi_wrdata_p1,
    output logic [2*DEVICE_TYPE-1:0]   dfi_wrdata_p2,
    output logic [2*DEVICE_TYPE-1:0]   dfi_wrdata_p3,
    output logic [DEVICE_TYPE/4-1:0]   dfi_wrdata_mask_p0,
    output logic [DEVICE_TYPE/4-1:0]   dfi_wrdata_mask_p1,
    output logic [DEVICE_TYPE/4-1:0]   dfi_wrdata_mask_p2,
    output logic [DEVICE_TYPE/4-1:0]   dfi_wrdata_mask_p3,
    output logic                       o_group_valid,
    output logic                       o_ratio_err
);

    localparam int W = 2*NUM_RANK + 14 + 1 + 2*DEVICE_TYPE + DEVICE_TYPE/4;

    typedef enum logic [1:0] {
        RATIO_1TO1,
        RATIO_1TO2,
        RATIO_1TO4
    } ratio_e;

    ratio_e       ratio_q;
    ratio_e       ratio_cur;
    logic [1:0]   phase_cnt;
    logic [1:0]   last_phase;
    logic         group_start;
    logic         code_illegal;
    logic         publish;
    logic [W-1:0] din;
    logic [W-1:0] slot [4];
    logic [W-1:0] pub  [4];

    // All six single-phase fields travel together as one word through staging.
    assign din = {dfi_cs_n, dfi_reset_n, dfi_address, dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask};

    always_comb begin
        group_start  = (phase_cnt == 2'd0);
        ratio_cur    = ratio_q;
        code_illegal = 1'b0;
        if (group_start) begin
            case (dfi_freq_ratio)
                3'b000:  ratio_cur = RATIO_1TO1;
                3'b001:  ratio_cur = RATIO_1TO2;
                3'b010:  ratio_cur = RATIO_1TO4;
                default: begin
                    ratio_cur    = RATIO_1TO1;
                    code_illegal = 1'b1;
                end
            endcase
        end
        case (ratio_cur)
            RATIO_1TO2: last_phase = 2'd1;
            RATIO_1TO4: last_phase = 2'd3;
            default:    last_phase = 2'd0;
        endcase
        publish = i_enable && (phase_cnt == last_phase);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            ratio_q       <= RATIO_1TO1;
            phase_cnt     <= '0;
            o_group_valid <= 1'b0;
            o_ratio_err   <= 1'b0;
            for (int unsigned k = 0; k < 4; k++) begin
                slot[k] <= '0;
                pub[k]  <= '0;
            end
        end else begin
            o_group_valid <= publish;
            if (i_enable) begin
                slot[phase_cnt] <= din;
                if (group_start) begin
                    ratio_q <= ratio_cur;
                end
                if (code_illegal) begin
                    o_ratio_err <= 1'b1;
                end
                phase_cnt <= publish ? 2'd0 : phase_cnt + 2'd1;
                // The final phase bypasses staging so the group publishes on its own edge.
                if (publish) begin
                    for (int unsigned k = 0; k < 4; k++) begin
                        if (2'(k) < last_phase) begin
                            pub[k] <= slot[k];
                        end else if (2'(k) == last_phase) begin
                            pub[k] <= din;
                        end else begin
                            pub[k] <= '0;
                        end
                    end
                end
            end
        end
    end

    assign {dfi_cs_n_p0, dfi_reset_n_p0, dfi_address_p0, dfi_wrdata_en_p0, dfi_wrdata_p0, dfi_wrdata_mask_p0} = pub[0];
    assign {dfi_cs_n_p1, dfi_reset_n_p1, dfi_address_p1, dfi_wrdata_en_p1, dfi_wrdata_p1, dfi_wrdata_mask_p1} = pub[1];
    assign {dfi_cs_n_p2, dfi_reset_n_p2, dfi_address_p2, dfi_wrdata_en_p2, dfi_wrdata_p2, dfi_wrdata_mask_p2} = pub[2];
    assign {dfi_cs_n_p3, dfi_reset_n_p3, dfi_address_p3, dfi_wrdata_en_p3, dfi_wrdata_p3, dfi_wrdata_mask_p3} = pub[3];

endmodule

// File: tb/tb_freq_ratio_phase_collector.sv
// Bench for freq_ratio_phase_collector: directed scenarios plus random traffic
// compared against a queue-based model of group collection.
module tb_freq_ratio_phase_collector;

    localparam int NUM_RANK    = 2;
    localparam int DEVICE_TYPE = 4;
    localparam int W = 2*NUM_RANK + 14 + 1 + 2*DEVICE_TYPE + DEVICE_TYPE/4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic [2:0]               ratio;
    logic [NUM_RANK-1:0]      cs_n;
    logic [NUM_RANK-1:0]      reset_n;
    logic [13:0]              address;
    logic                     wrdata_en;
    logic [2*DEVICE_TYPE-1:0] wrdata;
    logic [DEVICE_TYPE/4-1:0] mask;

    logic [NUM_RANK-1:0]      cs_n_p0, cs_n_p1, cs_n_p2, cs_n_p3;
    logic [NUM_RANK-1:0]      reset_n_p0, reset_n_p1, reset_n_p2, reset_n_p3;
    logic [13:0]              address_p0, address_p1, address_p2, address_p3;
    logic                     wrdata_en_p0, wrdata_en_p1, wrdata_en_p2, wrdata_en_p3;
    logic [2*DEVICE_TYPE-1:0] wrdata_p0, wrdata_p1, wrdata_p2, wrdata_p3;
    logic [DEVICE_TYPE/4-1:0] mask_p0, mask_p1, mask_p2, mask_p3;
    logic                     group_valid;
    logic                     ratio_err;

    int checks = 0;
    int errors = 0;

    // Reference model: the group being collected, its target size, expected outputs.
    logic [W-1:0] grp [$];
    int           grp_size;
    logic [W-1:0] exp_p [4];
    logic         exp_valid;
    logic         exp_err;

    logic [4*W+1:0] act_all;

    freq_ratio_phase_collector #(.NUM_RANK(NUM_RANK), .DEVICE_TYPE(DEVICE_TYPE)) dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .dfi_freq_ratio(ratio),
        .dfi_cs_n(cs_n), .dfi_reset_n(reset_n), .dfi_address(address),
        .dfi_wrdata_en(wrdata_en), .dfi_wrdata(wrdata), .dfi_wrdata_mask(mask),
        .dfi_cs_n_p0(cs_n_p0), .dfi_cs_n_p1(cs_n_p1), .dfi_cs_n_p2(cs_n_p2), .dfi_cs_n_p3(cs_n_p3),
        .dfi_reset_n_p0(reset_n_p0), .dfi_reset_n_p1(reset_n_p1),
        .dfi_reset_n_p2(reset_n_p2), .dfi_reset_n_p3(reset_n_p3),
        .dfi_address_p0(address_p0), .dfi_address_p1(address_p1),
        .dfi_address_p2(address_p2), .dfi_address_p3(address_p3),
        .dfi_wrdata_en_p0(wrdata_en_p0), .dfi_wrdata_en_p1(wrdata_en_p1),
        .dfi_wrdata_en_p2(wrdata_en_p2), .dfi_wrdata_en_p3(wrdata_en_p3),
        .dfi_wrdata_p0(wrdata_p0), .dfi_wrdata_p1(wrdata_p1),
        .dfi_wrdata_p2(wrdata_p2), .dfi_wrdata_p3(wrdata_p3),
        .dfi_wrdata_mask_p0(mask_p0), .dfi_wrdata_mask_p1(mask_p1),
        .dfi_wrdata_mask_p2(mask_p2), .dfi_wrdata_mask_p3(mask_p3),
        .o_group_valid(group_valid), .o_ratio_err(ratio_err)
    );

    always #5 clk = ~clk;

    assign act_all = {group_valid, ratio_err,
        cs_n_p0, reset_n_p0, address_p0, wrdata_en_p0, wrdata_p0, mask_p0,
        cs_n_p1, reset_n_p1, address_p1, wrdata_en_p1, wrdata_p1, mask_p1,
        cs_n_p2, reset_n_p2, address_p2, wrdata_en_p2, wrdata_p2, mask_p2,
        cs_n_p3, reset_n_p3, address_p3, wrdata_en_p3, wrdata_p3, mask_p3};

    function automatic logic [4*W+1:0] exp_vec();
        return {exp_valid, exp_err, exp_p[0], exp_p[1], exp_p[2], exp_p[3]};
    endfunction

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic step();
        logic [W-1:0] word;
        @(posedge clk);
        word = {cs_n, reset_n, address, wrdata_en, wrdata, mask};
        if (rst) begin
            grp.delete();
            for (int k = 0; k < 4; k++) exp_p[k] = '0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
        end else if (!en) begin
            exp_valid = 1'b0;
        end else begin
            if (grp.size() == 0) begin
                grp_size = (ratio == 3'd1) ? 2 : (ratio == 3'd2) ? 4 : 1;
                if (ratio > 3'd2) exp_err = 1'b1;
            end
            grp.push_back(word);
            if (grp.size() == grp_size) begin
                for (int k = 0; k < 4; k++) exp_p[k] = (k < grp_size) ? grp[k] : '0;
                exp_valid = 1'b1;
                grp.delete();
            end else begin
                exp_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic drive_rand();
        cs_n      = 2'($urandom);
        reset_n   = 2'($urandom);
        address   = 14'($urandom);
        wrdata_en = 1'($urandom);
        wrdata    = 8'($urandom);
        mask      = 1'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        drive_rand();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        ratio = 3'b010;
        drive_rand();
        step();
        step();
        checks++;
        if (act_all !== '0) begin
            errors++;
            $display("FAIL reset_state actual %h required 0", act_all);
        end
        checks++;
        if (act_all !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model actual %h required %h", act_all, exp_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_ratio4();
        logic [13:0] addrs [4];
        addrs = '{14'h0011, 14'h0022, 14'h0033, 14'h0044};
        do_reset();
        ratio = 3'b010;
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            address = addrs[i];
            step();
            checks++;
            if (act_all !== exp_vec()) begin
                errors++;
                $display("FAIL ratio4_model cyc %0d actual %h required %h", i, act_all, exp_vec());
            end
        end
        checks++;
        if ({group_valid, address_p0, address_p1, address_p2, address_p3} !==
            {1'b1, 14'h0011, 14'h0022, 14'h0033, 14'h0044}) begin
            errors++;
            $display("FAIL ratio4_group actual v=%b %h %h %h %h required v=1 0011 0022 0033 0044",
                     group_valid, address_p0, address_p1, address_p2, address_p3);
        end
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            step();
            checks++;
            if (group_valid !== (i == 3)) begin
                errors++;
                $display("FAIL ratio4_pulse cyc %0d actual %b required %b", i, group_valid, i == 3);
            end
        end
    endtask

    task automatic test_ratio2();
        do_reset();
        ratio = 3'b001;
        drive_rand();
        wrdata = 8'hA5;
        wrdata_en = 1'b1;
        step();
        checks++;
        if (group_valid !== 1'b0) begin
            errors++;
            $display("FAIL ratio2_first_half actual %b required 0", group_valid);
        end
        drive_rand();
        wrdata = 8'h5A;
        wrdata_en = 1'b0;
        step();
        checks++;
        if ({group_valid, wrdata_p0, wrdata_p1, wrdata_en_p0, wrdata_en_p1, address_p2, address_p3, wrdata_p3} !==
            {1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0, 14'h0, 14'h0, 8'h0}) begin
            errors++;
            $display("FAIL ratio2_group actual v=%b wd=%h/%h en=%b/%b a2=%h a3=%h required v=1 wd=a5/5a en=1/0 a2=0 a3=0",
                     group_valid, wrdata_p0, wrdata_p1, wrdata_en_p0, wrdata_en_p1, address_p2, address_p3);
        end
        for (int i = 0; i < 6; i++) begin
            drive_rand();
            step();
            checks++;
            if (act_all !== exp_vec() || group_valid !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL ratio2_model cyc %0d actual %h required %h", i, act_all, exp_vec());
            end
        end
    endtask

    task automatic test_ratio1();
        do_reset();
        ratio = 3'b000;
        for (int i = 0; i < 6; i++) begin
            drive_rand();
            cs_n = (i % 2 == 0) ? 2'b01 : 2'b10;
            step();
            checks++;
            if ({group_valid, cs_n_p0, cs_n_p1, address_p1} !== {1'b1, cs_n, 2'b00, 14'h0}) begin
                errors++;
                $display("FAIL ratio1_cs cyc %0d actual v=%b cs=%b required v=1 cs=%b", i, group_valid, cs_n_p0, cs_n);
            end
        end
    endtask

    task automatic test_stall();
        logic [13:0] a [4];
        do_reset();
        ratio = 3'b010;
        for (int i = 0; i < 4; i++) a[i] = 14'($urandom);
        for (int i = 0; i < 9; i++) begin
            drive_rand();
            en = !(i >= 2 && i <= 4);
            address = (i < 2) ? a[i] : (i > 4) ? a[(i - 3) % 4] : 14'($urandom);
            if (i >= 7) address = a[i - 5];
            step();
            checks++;
            if (act_all !== exp_vec()) begin
                errors++;
                $display("FAIL stall_model cyc %0d actual %h required %h", i, act_all, exp_vec());
            end
            if (i == 6) break;
        end
        checks++;
        if ({group_valid, address_p0, address_p1, address_p2, address_p3} !== {1'b1, a[0], a[1], a[2], a[3]}) begin
            errors++;
            $display("FAIL stall_group actual v=%b %h %h %h %h required v=1 %h %h %h %h",
                     group_valid, address_p0, address_p1, address_p2, address_p3, a[0], a[1], a[2], a[3]);
        end
        en = 1'b1;
    endtask

    task automatic test_ratio_switch();
        do_reset();
        ratio = 3'b010;
        for (int i = 0; i < 6; i++) begin
            drive_rand();
            if (i == 2) ratio = 3'b001;
            step();
            checks++;
            if (act_all !== exp_vec()) begin
                errors++;
                $display("FAIL switch_model cyc %0d actual %h required %h", i, act_all, exp_vec());
            end
            if (i == 3) begin
                checks++;
                if ({group_valid, address_p3} !== {1'b1, address}) begin
                    errors++;
                    $display("FAIL switch_as_1to4 actual v=%b a3=%h required v=1 a3=%h", group_valid, address_p3, address);
                end
            end
            if (i == 5) begin
                checks++;
                if ({group_valid, address_p1, address_p2, address_p3} !== {1'b1, address, 28'h0}) begin
                    errors++;
                    $display("FAIL switch_as_1to2 actual v=%b a1=%h a2=%h a3=%h required v=1 a1=%h a2=0 a3=0",
                             group_valid, address_p1, address_p2, address_p3, address);
                end
            end
        end
    endtask

    task automatic test_illegal_and_reset();
        do_reset();
        ratio = 3'b101;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            step();
            checks++;
            if ({group_valid, ratio_err, address_p0, address_p1} !== {2'b11, address, 14'h0}) begin
                errors++;
                $display("FAIL illegal_as_1to1 cyc %0d actual v=%b err=%b a0=%h required v=1 err=1 a0=%h",
                         i, group_valid, ratio_err, address_p0, address);
            end
        end
        ratio = 3'b010;
        drive_rand();
        step();
        drive_rand();
        step();
        checks++;
        if ({group_valid, ratio_err} !== 2'b01) begin
            errors++;
            $display("FAIL err_sticky actual v=%b err=%b required v=0 err=1", group_valid, ratio_err);
        end
        rst = 1'b1;
        drive_rand();
        step();
        checks++;
        if (act_all !== '0) begin
            errors++;
            $display("FAIL midgroup_reset actual %h required 0", act_all);
        end
        rst = 1'b0;
        en = 1'b0;
        step();
        checks++;
        if (act_all !== '0 || act_all !== exp_vec()) begin
            errors++;
            $display("FAIL after_reset actual %h required 0", act_all);
        end
        en = 1'b1;
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive_rand();
            r = $urandom_range(0, 19);
            ratio = (r == 19) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            en = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
            checks++;
            if (act_all !== exp_vec()) begin
                errors++;
                $display("FAIL random_model cyc %0d actual %h required %h", i, act_all, exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        ratio = 3'b000;
        cs_n = '0;
        reset_n = '0;
        address = '0;
        wrdata_en = 1'b0;
        wrdata = '0;
        mask = '0;
        grp_size = 1;
        exp_valid = 1'b0;
        exp_err = 1'b0;
        for (int k = 0; k < 4; k++) exp_p[k] = '0;
        test_reset();
        test_ratio4();
        test_ratio2();
        test_ratio1();
        test_stall();
        test_ratio_switch();
        test_illegal_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
